// File: rtl/mc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : mc_ctrl_pkg
// Brief   : Opcodes, FSM state encodings and datapath select encodings for the
//           multicycle RV32I control unit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_ctrl_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_data      = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;
    localparam logic [1:0] c_res_immext    = 2'b11;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rd1   = 2'b10;

    localparam logic [1:0] c_srcb_rd2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// Module  : alu_decoder
// Brief   : Maps ALUOp plus instruction fields to the 3-bit ALU operation.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = c_alu_add;
        case (i_alu_op)
            c_aluop_sub: o_alu_control = c_alu_sub;
            c_aluop_funct: begin
                case (i_funct3)
                    // Only R-type (op[5]=1) can encode sub; addi ignores bit 30.
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? c_alu_sub : c_alu_add;
                    3'b010:  o_alu_control = c_alu_slt;
                    3'b110:  o_alu_control = c_alu_or;
                    3'b111:  o_alu_control = c_alu_and;
                    default: o_alu_control = c_alu_add;
                endcase
            end
            default: o_alu_control = c_alu_add;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module  : multicycle_ctrl
// Brief   : Main control FSM of the multicycle RV32I core. Optional memory
//           handshake enabled by defining MC_CTRL_MEMREADY_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
`ifdef MC_CTRL_MEMREADY_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       IllegalInstr
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_dec_state;
    logic [1:0]         w_alu_op;
    logic               w_mem_ready;
    logic               w_pcwrite;
    logic               w_memwrite;
    logic               w_irwrite;
    logic               w_regwrite;
    logic               w_illegal;

`ifdef MC_CTRL_MEMREADY_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_W'(S_FETCH);
        end else begin
            r_state <= w_next;
        end
    end

    // During reset the non-enable outputs present their FETCH values.
    assign w_dec_state = reset ? STATE_W'(S_FETCH) : r_state;

    always_comb begin
        w_next     = STATE_W'(S_FETCH);
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = c_res_aluout;
        ALUSrcA    = c_srca_pc;
        ALUSrcB    = c_srcb_rd2;
        w_alu_op   = c_aluop_add;
        case (w_dec_state)
            STATE_W'(S_FETCH): begin
                w_irwrite = w_mem_ready;
                w_pcwrite = w_mem_ready;
                ALUSrcB   = c_srcb_four;
                ResultSrc = c_res_aluresult;
                w_next    = w_mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            end
            STATE_W'(S_DECODE): begin
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
                case (op)
                    OP_LW, OP_SW: w_next = STATE_W'(S_MEMADR);
                    OP_R:         w_next = STATE_W'(S_EXECUTER);
                    OP_I:         w_next = STATE_W'(S_EXECUTEI);
                    OP_JAL:       w_next = STATE_W'(S_JAL);
                    OP_BRANCH:    w_next = STATE_W'(S_BEQ);
                    OP_LUI:       w_next = STATE_W'(S_LUI);
                    default: begin
                        w_next    = STATE_W'(S_FETCH);
                        w_illegal = 1'b1;
                    end
                endcase
            end
            STATE_W'(S_MEMADR): begin
                ALUSrcA = c_srca_rd1;
                ALUSrcB = c_srcb_imm;
                w_next  = op[5] ? STATE_W'(S_MEMWRITE) : STATE_W'(S_MEMREAD);
            end
            STATE_W'(S_MEMREAD): begin
                AdrSrc = 1'b1;
                w_next = w_mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
            end
            STATE_W'(S_MEMWB): begin
                ResultSrc  = c_res_data;
                w_regwrite = 1'b1;
            end
            STATE_W'(S_MEMWRITE): begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_next     = w_mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
            end
            STATE_W'(S_EXECUTER): begin
                ALUSrcA  = c_srca_rd1;
                ALUSrcB  = c_srcb_rd2;
                w_alu_op = c_aluop_funct;
                w_next   = STATE_W'(S_ALUWB);
            end
            STATE_W'(S_EXECUTEI): begin
                ALUSrcA  = c_srca_rd1;
                ALUSrcB  = c_srcb_imm;
                w_alu_op = c_aluop_funct;
                w_next   = STATE_W'(S_ALUWB);
            end
            STATE_W'(S_ALUWB): begin
                w_regwrite = 1'b1;
            end
            STATE_W'(S_JAL): begin
                ALUSrcA   = c_srca_oldpc;
                ALUSrcB   = c_srcb_four;
                w_pcwrite = 1'b1;
                w_next    = STATE_W'(S_ALUWB);
            end
            STATE_W'(S_BEQ): begin
                ALUSrcA   = c_srca_rd1;
                ALUSrcB   = c_srcb_rd2;
                w_alu_op  = c_aluop_sub;
                // funct3[0] flips the sense for bne.
                w_pcwrite = Zero ^ funct3[0];
            end
            STATE_W'(S_LUI): begin
                ResultSrc  = c_res_immext;
                w_regwrite = 1'b1;
            end
            default: begin
                w_next = STATE_W'(S_FETCH);
            end
        endcase
    end

    assign PCWrite      = w_pcwrite  & ~reset;
    assign MemWrite     = w_memwrite & ~reset;
    assign IRWrite      = w_irwrite  & ~reset;
    assign RegWrite     = w_regwrite & ~reset;
    assign IllegalInstr = w_illegal  & ~reset;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_multicycle_ctrl
// Brief   : Directed self-checking bench for multicycle_ctrl.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
`ifdef MC_CTRL_MEMREADY_EN
    logic       MemReady = 1'b1;
`endif
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    // Observed vector: P A M I R | ResultSrc | ALUSrcA | ALUSrcB | ALUControl | Illegal
    logic [14:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, IllegalInstr};

    localparam logic [14:0] V_FETCH   = 15'b1_0_0_1_0_10_00_10_000_0;
    localparam logic [14:0] V_RSTF    = 15'b0_0_0_0_0_10_00_10_000_0;
    localparam logic [14:0] V_DEC     = 15'b0_0_0_0_0_00_01_01_000_0;
    localparam logic [14:0] V_DEC_ILL = 15'b0_0_0_0_0_00_01_01_000_1;
    localparam logic [14:0] V_MEMADR  = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_MEMRD   = 15'b0_1_0_0_0_00_00_00_000_0;
    localparam logic [14:0] V_MEMWB   = 15'b0_0_0_0_1_01_00_00_000_0;
    localparam logic [14:0] V_MEMWR   = 15'b0_1_1_0_0_00_00_00_000_0;
    localparam logic [14:0] V_ALUWB   = 15'b0_0_0_0_1_00_00_00_000_0;
    localparam logic [14:0] V_JAL     = 15'b1_0_0_0_0_00_01_10_000_0;
    localparam logic [14:0] V_BEQ_T   = 15'b1_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_BEQ_N   = 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_LUI     = 15'b0_0_0_0_1_11_00_00_000_0;
    localparam logic [14:0] V_EXR_SUB = 15'b0_0_0_0_0_00_10_00_001_0;
    localparam logic [14:0] V_EXR_ADD = 15'b0_0_0_0_0_00_10_00_000_0;
    localparam logic [14:0] V_EXR_AND = 15'b0_0_0_0_0_00_10_00_010_0;
    localparam logic [14:0] V_EXR_SLT = 15'b0_0_0_0_0_00_10_00_101_0;
    localparam logic [14:0] V_EXI_ADD = 15'b0_0_0_0_0_00_10_01_000_0;
    localparam logic [14:0] V_EXI_OR  = 15'b0_0_0_0_0_00_10_01_011_0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
`ifdef MC_CTRL_MEMREADY_EN
        .MemReady     (MemReady),
`endif
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .IllegalInstr (IllegalInstr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (obs !== V_RSTF) begin
            errors++;
            $display("FAIL reset_cycle1: got %b expected %b", obs, V_RSTF);
        end
        step();
        checks++;
        if (obs !== V_RSTF) begin
            errors++;
            $display("FAIL reset_cycle2: got %b expected %b", obs, V_RSTF);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL reset_release_fetch: got %b expected %b", obs, V_FETCH);
        end
    endtask

    task automatic test_lw();
        logic [14:0] exp [$];
        exp = '{V_FETCH, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
        op = 7'b0000011;
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: got %b expected %b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_sw();
        logic [14:0] exp [$];
        exp = '{V_FETCH, V_DEC, V_MEMADR, V_MEMWR, V_FETCH};
        op = 7'b0100011;
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: got %b expected %b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [2:0]  f3  [4] = '{3'b000, 3'b000, 3'b111, 3'b010};
        logic        f7  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [14:0] ex  [4] = '{V_EXR_SUB, V_EXR_ADD, V_EXR_AND, V_EXR_SLT};
        logic [14:0] exp [$];
        op = 7'b0110011;
        for (int v = 0; v < 4; v++) begin
            funct3   = f3[v];
            funct7b5 = f7[v];
            exp = '{V_FETCH, V_DEC, ex[v], V_ALUWB, V_FETCH};
            for (int i = 0; i < exp.size(); i++) begin
                if (i != 0) step();
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL rtype v%0d cycle %0d: got %b expected %b", v, i + 1, obs, exp[i]);
                end
            end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_itype();
        logic [2:0]  f3  [2] = '{3'b000, 3'b110};
        logic [14:0] ex  [2] = '{V_EXI_ADD, V_EXI_OR};
        logic [14:0] exp [$];
        op       = 7'b0010011;
        funct7b5 = 1'b1;
        for (int v = 0; v < 2; v++) begin
            funct3 = f3[v];
            exp = '{V_FETCH, V_DEC, ex[v], V_ALUWB, V_FETCH};
            for (int i = 0; i < exp.size(); i++) begin
                if (i != 0) step();
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL itype v%0d cycle %0d: got %b expected %b", v, i + 1, obs, exp[i]);
                end
            end
        end
        funct7b5 = 1'b0;
        funct3   = 3'b000;
    endtask

    task automatic test_jal();
        logic [14:0] exp [$];
        exp = '{V_FETCH, V_DEC, V_JAL, V_ALUWB, V_FETCH};
        op = 7'b1101111;
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL jal cycle %0d: got %b expected %b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3  [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic        z   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [14:0] ex  [4] = '{V_BEQ_T, V_BEQ_N, V_BEQ_T, V_BEQ_N};
        logic [14:0] exp [$];
        op = 7'b1100011;
        for (int v = 0; v < 4; v++) begin
            funct3 = f3[v];
            Zero   = z[v];
            exp = '{V_FETCH, V_DEC, ex[v], V_FETCH};
            for (int i = 0; i < exp.size(); i++) begin
                if (i != 0) step();
                checks++;
                if (obs !== exp[i]) begin
                    errors++;
                    $display("FAIL branch v%0d cycle %0d: got %b expected %b", v, i + 1, obs, exp[i]);
                end
            end
        end
        Zero   = 1'b0;
        funct3 = 3'b000;
    endtask

    task automatic test_lui();
        logic [14:0] exp [$];
        exp = '{V_FETCH, V_DEC, V_LUI, V_FETCH};
        op = 7'b0110111;
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL lui cycle %0d: got %b expected %b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp [$];
        exp = '{V_FETCH, V_DEC_ILL, V_FETCH};
        op = 7'b1111111;
        for (int i = 0; i < exp.size(); i++) begin
            if (i != 0) step();
            checks++;
            if (obs !== exp[i]) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %b expected %b", i + 1, obs, exp[i]);
            end
        end
    endtask

    task automatic test_reset_midinstr();
        op = 7'b0100011;
        step();
        step();
        step();
        checks++;
        if (obs !== V_MEMWR) begin
            errors++;
            $display("FAIL rstmid_memwrite: got %b expected %b", obs, V_MEMWR);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== V_RSTF) begin
            errors++;
            $display("FAIL rstmid_reset_cycle: got %b expected %b", obs, V_RSTF);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL rstmid_fetch: got %b expected %b", obs, V_FETCH);
        end
        step();
        checks++;
        if (obs !== V_MEMADR && obs !== V_DEC) begin
            errors++;
            $display("FAIL rstmid_decode: got %b expected %b", obs, V_DEC);
        end
        // Leave the sw in flight to FETCH before the next test.
        step();
        step();
        step();
    endtask

`ifdef MC_CTRL_MEMREADY_EN
    task automatic test_memready();
        op = 7'b0110111;
        MemReady = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== V_RSTF) begin
                errors++;
                $display("FAIL memready_stall %0d: got %b expected %b", i, obs, V_RSTF);
            end
            step();
        end
        MemReady = 1'b1;
        #1;
        checks++;
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL memready_fetch: got %b expected %b", obs, V_FETCH);
        end
        step();
        checks++;
        if (obs !== V_DEC) begin
            errors++;
            $display("FAIL memready_decode: got %b expected %b", obs, V_DEC);
        end
        step();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_itype();
        test_jal();
        test_branch();
        test_lui();
        test_illegal();
        test_reset_midinstr();
        checks++;
        if (obs !== V_FETCH) begin
            errors++;
            $display("FAIL post_rstmid_fetch: got %b expected %b", obs, V_FETCH);
        end
`ifdef MC_CTRL_MEMREADY_EN
        test_memready();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
